// File: rtl/dbi_tx_sequencer_if.sv
// ============================================================================
// Module      : dbi_tx_sequencer_if
// Description : Pixel-in and DBI-TX-out byte handshakes of dbi_tx_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface dbi_tx_sequencer_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] pix_data_i;
    logic              pix_valid_i;
    logic              pix_ready_o;
    logic [DATA_W-1:0] tx_data_o;
    logic              tx_dcx_o;
    logic              tx_valid_o;
    logic              tx_ready_i;

    modport master (
        input  pix_data_i, pix_valid_i, tx_ready_i,
        output pix_ready_o, tx_data_o, tx_dcx_o, tx_valid_o
    );

    modport slave (
        output pix_data_i, pix_valid_i, tx_ready_i,
        input  pix_ready_o, tx_data_o, tx_dcx_o, tx_valid_o
    );
endinterface

`default_nettype wire

// File: rtl/dbi_tx_sequencer.sv
// ============================================================================
// Module      : dbi_tx_sequencer
// Description : Emits the DBI panel-init command/parameter bytes followed by
//               one frame of pixel bytes per start edge. Define
//               DBI_RST_WAIT_EN to insert an idle wait after soft reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module dbi_tx_sequencer #(
    parameter int DATA_W       = 8,
    parameter int PIXEL_BYTES  = 153600,
    parameter int PIX_CNT_W    = 18,
    parameter int RST_WAIT_CYC = 16,
    parameter int WAIT_CNT_W   = 5
) (
    input  wire                clk,
    input  wire                rst_n,
    input  wire                dbi_tx_start_i,
    input  wire  [DATA_W-1:0]  addr_soft_rst_i,
    input  wire  [DATA_W-1:0]  addr_disp_on_i,
    input  wire  [DATA_W-1:0]  addr_acs_ctrl_i,
    input  wire  [DATA_W-1:0]  addr_col_i,
    input  wire  [DATA_W-1:0]  addr_row_i,
    input  wire  [DATA_W-1:0]  addr_mem_wr_i,
    input  wire  [DATA_W-1:0]  cmd_acs_ctrl_i,
    input  wire  [DATA_W-1:0]  cmd_s_col_h_i,
    input  wire  [DATA_W-1:0]  cmd_s_col_l_i,
    input  wire  [DATA_W-1:0]  cmd_e_col_h_i,
    input  wire  [DATA_W-1:0]  cmd_e_col_l_i,
    input  wire  [DATA_W-1:0]  cmd_s_row_h_i,
    input  wire  [DATA_W-1:0]  cmd_s_row_l_i,
    input  wire  [DATA_W-1:0]  cmd_e_row_h_i,
    input  wire  [DATA_W-1:0]  cmd_e_row_l_i,
    dbi_tx_sequencer_if.master bus,
    output logic               busy_o,
    output logic               frame_done_o
);

    localparam logic [3:0] S_IDLE   = 4'd0;
    localparam logic [3:0] S_SRST   = 4'd1;
    localparam logic [3:0] S_WAIT   = 4'd2;
    localparam logic [3:0] S_DISPON = 4'd3;
    localparam logic [3:0] S_MADCTL = 4'd4;
    localparam logic [3:0] S_COL    = 4'd5;
    localparam logic [3:0] S_ROW    = 4'd6;
    localparam logic [3:0] S_MEMWR  = 4'd7;
    localparam logic [3:0] S_PIXEL  = 4'd8;

    localparam logic [PIX_CNT_W-1:0] c_PIX_LAST = PIX_CNT_W'(PIXEL_BYTES - 1);

`ifdef DBI_RST_WAIT_EN
    localparam logic [3:0] c_AFTER_SRST = S_WAIT;
    localparam logic [WAIT_CNT_W-1:0] c_WAIT_LAST = WAIT_CNT_W'(RST_WAIT_CYC - 1);
    logic [WAIT_CNT_W-1:0] r_wait_cnt;
`else
    localparam logic [3:0] c_AFTER_SRST = S_DISPON;
`endif

    logic [3:0]           r_state;
    logic [2:0]           r_idx;
    logic                 r_start_d;
    logic                 r_start_armed;
    logic [PIX_CNT_W-1:0] r_pix_cnt;
    logic [DATA_W-1:0]    r_tx_data;
    logic                 r_tx_dcx;
    logic                 r_tx_valid;
    logic                 r_frame_done;

    logic [DATA_W-1:0] r_addr_soft_rst, r_addr_disp_on, r_addr_acs_ctrl;
    logic [DATA_W-1:0] r_addr_col, r_addr_row, r_addr_mem_wr;
    logic [DATA_W-1:0] r_cmd_acs_ctrl;
    logic [DATA_W-1:0] r_cmd_s_col_h, r_cmd_s_col_l, r_cmd_e_col_h, r_cmd_e_col_l;
    logic [DATA_W-1:0] r_cmd_s_row_h, r_cmd_s_row_l, r_cmd_e_row_h, r_cmd_e_row_l;

    logic              w_start_edge;
    logic              w_acc;
    logic              w_slot;
    logic              w_last_pix;
    logic              w_pix_ready;
    logic              w_pix_take;
    logic [2:0]        w_last_idx;
    logic [3:0]        w_next_state;
    logic              w_at_last;
    logic [3:0]        w_sel_state;
    logic [2:0]        w_sel_idx;
    logic [DATA_W-1:0] w_cmd_data;
    logic              w_cmd_dcx;
    logic              w_cmd_vld;

    // The armed flag keeps a start level held through reset from looking like an edge.
    assign w_start_edge = dbi_tx_start_i & ~r_start_d & r_start_armed;
    assign w_acc        = r_tx_valid & bus.tx_ready_i;
    assign w_slot       = ~r_tx_valid | bus.tx_ready_i;
    assign w_last_pix   = (r_pix_cnt == c_PIX_LAST);
    assign w_pix_ready  = (r_state == S_PIXEL) & w_slot & ~(r_tx_valid & w_last_pix);
    assign w_pix_take   = w_pix_ready & bus.pix_valid_i;

    always_comb begin
        w_last_idx   = 3'd0;
        w_next_state = S_IDLE;
        case (r_state)
            S_SRST:   w_next_state = c_AFTER_SRST;
            S_DISPON: w_next_state = S_MADCTL;
            S_MADCTL: begin w_last_idx = 3'd1; w_next_state = S_COL;   end
            S_COL:    begin w_last_idx = 3'd4; w_next_state = S_ROW;   end
            S_ROW:    begin w_last_idx = 3'd4; w_next_state = S_MEMWR; end
            S_MEMWR:  w_next_state = S_PIXEL;
            default:  w_next_state = S_IDLE;
        endcase
    end

    assign w_at_last = (r_idx == w_last_idx);

    // Pick the byte that goes into the output register this cycle: the current
    // one on first entry, the next one in this state, or the first of the next state.
    always_comb begin
        w_sel_state = r_state;
        w_sel_idx   = r_idx;
        if (r_state == S_WAIT) begin
            w_sel_state = S_DISPON;
            w_sel_idx   = 3'd0;
        end else if (r_tx_valid) begin
            if (w_at_last) begin
                w_sel_state = w_next_state;
                w_sel_idx   = 3'd0;
            end else begin
                w_sel_idx   = r_idx + 3'd1;
            end
        end
    end

    always_comb begin
        w_cmd_data = '0;
        w_cmd_dcx  = 1'b1;
        w_cmd_vld  = 1'b1;
        case (w_sel_state)
            S_SRST:   begin w_cmd_data = r_addr_soft_rst; w_cmd_dcx = 1'b0; end
            S_DISPON: begin w_cmd_data = r_addr_disp_on;  w_cmd_dcx = 1'b0; end
            S_MADCTL: begin
                if (w_sel_idx == 3'd0) begin
                    w_cmd_data = r_addr_acs_ctrl;
                    w_cmd_dcx  = 1'b0;
                end else begin
                    w_cmd_data = r_cmd_acs_ctrl;
                end
            end
            S_COL: begin
                case (w_sel_idx)
                    3'd0:    begin w_cmd_data = r_addr_col; w_cmd_dcx = 1'b0; end
                    3'd1:    w_cmd_data = r_cmd_s_col_h;
                    3'd2:    w_cmd_data = r_cmd_s_col_l;
                    3'd3:    w_cmd_data = r_cmd_e_col_h;
                    default: w_cmd_data = r_cmd_e_col_l;
                endcase
            end
            S_ROW: begin
                case (w_sel_idx)
                    3'd0:    begin w_cmd_data = r_addr_row; w_cmd_dcx = 1'b0; end
                    3'd1:    w_cmd_data = r_cmd_s_row_h;
                    3'd2:    w_cmd_data = r_cmd_s_row_l;
                    3'd3:    w_cmd_data = r_cmd_e_row_h;
                    default: w_cmd_data = r_cmd_e_row_l;
                endcase
            end
            S_MEMWR:  begin w_cmd_data = r_addr_mem_wr; w_cmd_dcx = 1'b0; end
            default:  w_cmd_vld = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= S_IDLE;
            r_idx           <= 3'd0;
            r_start_d       <= 1'b0;
            r_start_armed   <= 1'b0;
            r_pix_cnt       <= '0;
            r_tx_data       <= '0;
            r_tx_dcx        <= 1'b0;
            r_tx_valid      <= 1'b0;
            r_frame_done    <= 1'b0;
            r_addr_soft_rst <= '0;
            r_addr_disp_on  <= '0;
            r_addr_acs_ctrl <= '0;
            r_addr_col      <= '0;
            r_addr_row      <= '0;
            r_addr_mem_wr   <= '0;
            r_cmd_acs_ctrl  <= '0;
            r_cmd_s_col_h   <= '0;
            r_cmd_s_col_l   <= '0;
            r_cmd_e_col_h   <= '0;
            r_cmd_e_col_l   <= '0;
            r_cmd_s_row_h   <= '0;
            r_cmd_s_row_l   <= '0;
            r_cmd_e_row_h   <= '0;
            r_cmd_e_row_l   <= '0;
`ifdef DBI_RST_WAIT_EN
            r_wait_cnt      <= '0;
`endif
        end else begin
            r_start_d     <= dbi_tx_start_i;
            r_start_armed <= 1'b1;
            r_frame_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_addr_soft_rst <= addr_soft_rst_i;
                        r_addr_disp_on  <= addr_disp_on_i;
                        r_addr_acs_ctrl <= addr_acs_ctrl_i;
                        r_addr_col      <= addr_col_i;
                        r_addr_row      <= addr_row_i;
                        r_addr_mem_wr   <= addr_mem_wr_i;
                        r_cmd_acs_ctrl  <= cmd_acs_ctrl_i;
                        r_cmd_s_col_h   <= cmd_s_col_h_i;
                        r_cmd_s_col_l   <= cmd_s_col_l_i;
                        r_cmd_e_col_h   <= cmd_e_col_h_i;
                        r_cmd_e_col_l   <= cmd_e_col_l_i;
                        r_cmd_s_row_h   <= cmd_s_row_h_i;
                        r_cmd_s_row_l   <= cmd_s_row_l_i;
                        r_cmd_e_row_h   <= cmd_e_row_h_i;
                        r_cmd_e_row_l   <= cmd_e_row_l_i;
                        r_state         <= S_SRST;
                        r_idx           <= 3'd0;
                    end
                end
`ifdef DBI_RST_WAIT_EN
                S_WAIT: begin
                    if (r_wait_cnt == c_WAIT_LAST) begin
                        r_wait_cnt <= '0;
                        r_state    <= S_DISPON;
                        r_idx      <= 3'd0;
                        r_tx_data  <= w_cmd_data;
                        r_tx_dcx   <= w_cmd_dcx;
                        r_tx_valid <= 1'b1;
                    end else begin
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    end
                end
`endif
                S_SRST, S_DISPON, S_MADCTL, S_COL, S_ROW, S_MEMWR: begin
                    if (w_slot) begin
                        if (w_acc && w_at_last) begin
                            r_state <= w_next_state;
                            r_idx   <= 3'd0;
                        end else if (w_acc) begin
                            r_idx   <= r_idx + 3'd1;
                        end
                        r_tx_valid <= w_cmd_vld;
                        if (w_cmd_vld) begin
                            r_tx_data <= w_cmd_data;
                            r_tx_dcx  <= w_cmd_dcx;
                        end
                    end
                end
                S_PIXEL: begin
                    if (w_acc && w_last_pix) begin
                        r_state      <= S_IDLE;
                        r_pix_cnt    <= '0;
                        r_frame_done <= 1'b1;
                        r_tx_valid   <= 1'b0;
                    end else begin
                        if (w_acc) begin
                            r_pix_cnt <= r_pix_cnt + 1'b1;
                        end
                        if (w_pix_take) begin
                            r_tx_data  <= bus.pix_data_i;
                            r_tx_dcx   <= 1'b1;
                            r_tx_valid <= 1'b1;
                        end else if (w_acc) begin
                            r_tx_valid <= 1'b0;
                        end
                    end
                end
                default: begin
                    r_state    <= S_IDLE;
                    r_tx_valid <= 1'b0;
                end
            endcase
        end
    end

    assign bus.tx_data_o   = r_tx_data;
    assign bus.tx_dcx_o    = r_tx_dcx;
    assign bus.tx_valid_o  = r_tx_valid;
    assign bus.pix_ready_o = w_pix_ready;
    assign busy_o          = (r_state != S_IDLE);
    assign frame_done_o    = r_frame_done;

endmodule

`default_nettype wire

// File: tb/tb_dbi_tx_sequencer.sv
// ============================================================================
// Module      : tb_dbi_tx_sequencer
// Description : Directed self-checking bench for dbi_tx_sequencer (8-byte frame).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_dbi_tx_sequencer;

    localparam int c_PIX = 8;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a_srst, a_don, a_acs, a_col, a_row, a_mwr;
    logic [7:0] p_acs, p_sch, p_scl, p_ech, p_ecl, p_srh, p_srl, p_erh, p_erl;
    logic       busy;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    logic [7:0] got_data [$];
    logic       got_dcx  [$];
    logic [7:0] exp_data [15];
    logic       exp_dcx  [15];
    int         exp_gap;

    dbi_tx_sequencer_if #(.DATA_W(8)) bus ();

    dbi_tx_sequencer #(
        .DATA_W       (8),
        .PIXEL_BYTES  (c_PIX),
        .PIX_CNT_W    (4),
        .RST_WAIT_CYC (16),
        .WAIT_CNT_W   (5)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .dbi_tx_start_i  (start),
        .addr_soft_rst_i (a_srst),
        .addr_disp_on_i  (a_don),
        .addr_acs_ctrl_i (a_acs),
        .addr_col_i      (a_col),
        .addr_row_i      (a_row),
        .addr_mem_wr_i   (a_mwr),
        .cmd_acs_ctrl_i  (p_acs),
        .cmd_s_col_h_i   (p_sch),
        .cmd_s_col_l_i   (p_scl),
        .cmd_e_col_h_i   (p_ech),
        .cmd_e_col_l_i   (p_ecl),
        .cmd_s_row_h_i   (p_srh),
        .cmd_s_row_l_i   (p_srl),
        .cmd_e_row_h_i   (p_erh),
        .cmd_e_row_l_i   (p_erl),
        .bus             (bus),
        .busy_o          (busy),
        .frame_done_o    (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_cfg();
        a_srst = 8'h01; a_don = 8'h29; a_acs = 8'h36;
        a_col  = 8'h2A; a_row = 8'h2B; a_mwr = 8'h2C;
        p_acs = 8'h08; p_sch = 8'h00; p_scl = 8'h00; p_ech = 8'h00; p_ecl = 8'hEF;
        p_srh = 8'h00; p_srl = 8'h00; p_erh = 8'h01; p_erl = 8'h3F;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    // Collects n accepted TX bytes, noting first-valid latency, the idle gap
    // after the first byte, and whether stalled bytes held steady.
    task automatic collect_bytes(input int n, input bit rand_ready, output int first_valid,
                                 output int gap, output bit stable_ok, output bit timed_out);
        logic [7:0] hold_d;
        logic       hold_dcx;
        bit         holding;
        got_data.delete();
        got_dcx.delete();
        first_valid = 0; gap = 0; stable_ok = 1'b1; timed_out = 1'b1;
        holding = 1'b0; hold_d = 8'h00; hold_dcx = 1'b0;
        for (int cyc = 1; cyc <= 3000; cyc++) begin
            @(posedge clk); #1;
            if (holding && (bus.tx_valid_o !== 1'b1 || bus.tx_data_o !== hold_d ||
                            bus.tx_dcx_o !== hold_dcx))
                stable_ok = 1'b0;
            if (first_valid == 0 && bus.tx_valid_o === 1'b1) first_valid = cyc;
            if (got_data.size() == 1 && bus.tx_valid_o !== 1'b1) gap++;
            bus.tx_ready_i = rand_ready ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (bus.tx_valid_o === 1'b1 && bus.tx_ready_i) begin
                got_data.push_back(bus.tx_data_o);
                got_dcx.push_back(bus.tx_dcx_o);
                holding = 1'b0;
            end else begin
                holding  = (bus.tx_valid_o === 1'b1);
                hold_d   = bus.tx_data_o;
                hold_dcx = bus.tx_dcx_o;
            end
            if (got_data.size() == n) begin
                timed_out = 1'b0;
                break;
            end
        end
    endtask

    // Feeds pixels A0,A1,... with random valid gaps and random TX stalls until
    // frame_done has been seen and a few more cycles have passed.
    task automatic run_frame(output int pulls, output int fd_cnt, output bit busy_at_fd,
                             output bit timed_out);
        int tail;
        got_data.delete();
        got_dcx.delete();
        pulls = 0; fd_cnt = 0; busy_at_fd = 1'b1; timed_out = 1'b1; tail = -1;
        for (int cyc = 0; cyc < 1000; cyc++) begin
            @(posedge clk); #1;
            if (frame_done === 1'b1) begin
                fd_cnt++;
                busy_at_fd = busy;
                if (tail < 0) tail = 0;
            end
            bus.tx_ready_i  = ($urandom_range(0, 3) != 0);
            bus.pix_valid_i = ($urandom_range(0, 2) != 0);
            bus.pix_data_i  = 8'hA0 + 8'(pulls);
            #1;
            if (bus.tx_valid_o === 1'b1 && bus.tx_ready_i) begin
                got_data.push_back(bus.tx_data_o);
                got_dcx.push_back(bus.tx_dcx_o);
            end
            if (bus.pix_valid_i && bus.pix_ready_o === 1'b1) pulls++;
            if (tail >= 0) begin
                tail++;
                if (tail == 4) begin
                    timed_out = 1'b0;
                    break;
                end
            end
        end
        bus.pix_valid_i = 1'b0;
    endtask

    task automatic test_reset();
        start = 1'b0;
        bus.tx_ready_i = 1'b1;
        rst_n = 1'b0;
        #2;
        checks++;
        if ({bus.tx_valid_o, bus.tx_dcx_o, bus.tx_data_o, bus.pix_ready_o, busy, frame_done} !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %b required 0",
                     {bus.tx_valid_o, bus.tx_dcx_o, bus.tx_data_o, bus.pix_ready_o, busy, frame_done});
        end
        do_reset();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({bus.tx_valid_o, busy, frame_done, bus.pix_ready_o} !== 4'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %b required 0000",
                     {bus.tx_valid_o, busy, frame_done, bus.pix_ready_o});
        end
    endtask

    task automatic test_startup();
        int fv, gap;
        bit st, to;
        set_cfg();
        start = 1'b1;
        collect_bytes(15, 1'b0, fv, gap, st, to);
        checks++;
        if (to !== 1'b0 || got_data.size() != 15) begin
            errors++;
            $display("FAIL startup_count: got %0d bytes required 15", got_data.size());
        end
        checks++;
        if (fv != 2) begin
            errors++;
            $display("FAIL startup_latency: got %0d required 2", fv);
        end
        checks++;
        if (gap != exp_gap) begin
            errors++;
            $display("FAIL reset_wait_gap: got %0d required %0d", gap, exp_gap);
        end
        for (int i = 0; i < got_data.size() && i < 15; i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_dcx[i] !== exp_dcx[i]) begin
                errors++;
                $display("FAIL startup_byte%0d: got %h/%b required %h/%b",
                         i, got_data[i], got_dcx[i], exp_data[i], exp_dcx[i]);
            end
        end
    endtask

    task automatic test_frame();
        int pulls, fd_cnt;
        bit bfd, to;
        run_frame(pulls, fd_cnt, bfd, to);
        checks++;
        if (to !== 1'b0 || got_data.size() != c_PIX) begin
            errors++;
            $display("FAIL frame_count: got %0d bytes required %0d", got_data.size(), c_PIX);
        end
        for (int i = 0; i < got_data.size() && i < c_PIX; i++) begin
            checks++;
            if (got_data[i] !== 8'hA0 + 8'(i) || got_dcx[i] !== 1'b1) begin
                errors++;
                $display("FAIL frame_pix%0d: got %h/%b required %h/1",
                         i, got_data[i], got_dcx[i], 8'hA0 + 8'(i));
            end
        end
        checks++;
        if (pulls != c_PIX) begin
            errors++;
            $display("FAIL frame_pulls: got %0d required %0d", pulls, c_PIX);
        end
        checks++;
        if (fd_cnt != 1) begin
            errors++;
            $display("FAIL frame_done_pulses: got %0d required 1", fd_cnt);
        end
        checks++;
        if (bfd !== 1'b0) begin
            errors++;
            $display("FAIL busy_at_frame_done: got %b required 0", bfd);
        end
    endtask

    task automatic test_back_to_back();
        int fv, gap;
        bit st, to;
        start = 1'b0;
        set_cfg();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        p_scl = 8'h55;
        collect_bytes(15, 1'b1, fv, gap, st, to);
        checks++;
        if (to !== 1'b0 || got_data.size() != 15) begin
            errors++;
            $display("FAIL bp_count: got %0d bytes required 15", got_data.size());
        end
        checks++;
        if (st !== 1'b1) begin
            errors++;
            $display("FAIL bp_stable: got %b required 1", st);
        end
        for (int i = 0; i < got_data.size() && i < 15; i++) begin
            checks++;
            if (got_data[i] !== exp_data[i] || got_dcx[i] !== exp_dcx[i]) begin
                errors++;
                $display("FAIL bp_byte%0d: got %h/%b required %h/%b",
                         i, got_data[i], got_dcx[i], exp_data[i], exp_dcx[i]);
            end
        end
    endtask

    task automatic test_retrigger();
        int pulls, fd_cnt, act;
        bit bfd, to;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        run_frame(pulls, fd_cnt, bfd, to);
        checks++;
        if (to !== 1'b0 || fd_cnt != 1 || got_data.size() != c_PIX) begin
            errors++;
            $display("FAIL retrigger_frame: got %0d pulses %0d bytes required 1 %0d",
                     fd_cnt, got_data.size(), c_PIX);
        end
        act = 0;
        bus.tx_ready_i = 1'b1;
        repeat (30) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || bus.tx_valid_o === 1'b1) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL retrigger_ignored: got %0d active cycles required 0", act);
        end
    endtask

    task automatic test_reset_in_pixel();
        int fv, gap, k, acc, act;
        bit st, to;
        start = 1'b0;
        set_cfg();
        @(posedge clk); #1;
        start = 1'b1;
        collect_bytes(15, 1'b0, fv, gap, st, to);
        k = 0; acc = 0;
        bus.tx_ready_i = 1'b1;
        for (int cyc = 0; cyc < 200 && acc < 3; cyc++) begin
            @(posedge clk); #1;
            bus.pix_valid_i = 1'b1;
            bus.pix_data_i  = 8'hA0 + 8'(k);
            #1;
            if (bus.tx_valid_o === 1'b1 && bus.tx_dcx_o === 1'b1) acc++;
            if (bus.pix_ready_o === 1'b1) k++;
        end
        checks++;
        if (acc != 3) begin
            errors++;
            $display("FAIL rst_pix_prefill: got %0d bytes required 3", acc);
        end
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.tx_valid_o, bus.tx_dcx_o, bus.tx_data_o, bus.pix_ready_o, busy, frame_done} !== 13'd0) begin
            errors++;
            $display("FAIL rst_in_pixel_outputs: got %b required 0",
                     {bus.tx_valid_o, bus.tx_dcx_o, bus.tx_data_o, bus.pix_ready_o, busy, frame_done});
        end
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        act = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (busy === 1'b1 || bus.tx_valid_o === 1'b1 || bus.pix_ready_o === 1'b1) act++;
        end
        checks++;
        if (act != 0) begin
            errors++;
            $display("FAIL held_start_after_reset: got %0d active cycles required 0", act);
        end
        bus.pix_valid_i = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        collect_bytes(1, 1'b0, fv, gap, st, to);
        checks++;
        if (to !== 1'b0 || fv != 2 || got_data[0] !== 8'h01 || got_dcx[0] !== 1'b0) begin
            errors++;
            $display("FAIL restart_after_reset: got latency %0d byte %h required 2 01", fv,
                     (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
        start = 1'b0;
        do_reset();
    endtask

    initial begin
        exp_data = '{8'h01, 8'h29, 8'h36, 8'h08, 8'h2A, 8'h00, 8'h00, 8'h00,
                     8'hEF, 8'h2B, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2C};
        exp_dcx  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1,
                     1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
`ifdef DBI_RST_WAIT_EN
        exp_gap = 16;
`else
        exp_gap = 0;
`endif
        rst_n = 1'b0;
        start = 1'b0;
        bus.tx_ready_i  = 1'b1;
        bus.pix_valid_i = 1'b0;
        bus.pix_data_i  = 8'h00;
        set_cfg();

        test_reset();
        test_startup();
        test_frame();
        test_back_to_back();
        test_retrigger();
        test_reset_in_pixel();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
